// File: rtl/control_display.sv
// Four-digit multiplexed 7-segment driver: serial double-dabble binary-to-BCD converter plus digit scanner.
// Optional macro BLANK_LEADING_ZEROS_EN disables the anode of zero digits above the most significant nonzero digit.
module control_display #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] valor_in,
    input  logic        cargar_in,
    output logic        ocupado_out,
    output logic [7:0]  digito_out,
    output logic [3:0]  anodo_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [19:0] PRESC_MAX = 20'(SCAN_DIV - 1);

    state_t           state_q, state_d;
    logic [13:0]      bin_q, bin_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [3:0]       iter_q, iter_d;
    logic             ovf_q, ovf_d;
    logic [3:0][7:0]  disp_q, disp_d;
    logic [19:0]      presc_q, presc_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       anodo_q, anodo_d;
    logic [7:0]       digito_q, digito_d;
    logic [3:0]       blank_s;
    logic [15:0]      adj_s;

    function automatic logic [15:0] dabble_adj(input logic [15:0] b);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = b[4*i +: 4];
            end
        end
        return r;
    endfunction

`ifdef BLANK_LEADING_ZEROS_EN
    // Overflow dashes are 8'hFF, never zero, so they are never blanked.
    function automatic logic [3:0] lead_zero_mask(input logic [3:0][7:0] d);
        logic [3:0] m;
        m[3] = (d[3] == 8'h00);
        m[2] = m[3] && (d[2] == 8'h00);
        m[1] = m[2] && (d[1] == 8'h00);
        m[0] = 1'b0;
        return m;
    endfunction
`endif

    // Conversion FSM: load, fourteen double-dabble steps, publish to the display registers.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        ovf_d   = ovf_q;
        disp_d  = disp_q;
        adj_s   = dabble_adj(bcd_q);
        case (state_q)
            IDLE: begin
                if (cargar_in) begin
                    bin_d   = valor_in;
                    bcd_d   = 16'h0000;
                    iter_d  = 4'd0;
                    ovf_d   = (valor_in > 14'd9999);
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                {bcd_d, bin_d} = {adj_s[14:0], bin_q, 1'b0};
                iter_d         = iter_q + 4'd1;
                if (iter_q == 4'd13) begin
                    state_d = FIN;
                end else begin
                    state_d = CONV;
                end
            end
            FIN: begin
                if (ovf_q) begin
                    disp_d = {4{8'hFF}};
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        disp_d[i] = {4'h0, bcd_q[4*i +: 4]};
                    end
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Free-running scanner; outputs are computed from next-state so the registered outputs track the index exactly.
    always_comb begin
        if (presc_q == PRESC_MAX) begin
            presc_d = 20'd0;
            idx_d   = idx_q + 2'd1;
        end else begin
            presc_d = presc_q + 20'd1;
            idx_d   = idx_q;
        end
`ifdef BLANK_LEADING_ZEROS_EN
        blank_s = lead_zero_mask(disp_d);
`else
        blank_s = 4'b0000;
`endif
        if (blank_s[idx_d]) begin
            anodo_d = 4'b1111;
        end else begin
            anodo_d = ~(4'b0001 << idx_d);
        end
        digito_d = disp_d[idx_d];
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bin_q    <= 14'd0;
            bcd_q    <= 16'h0000;
            iter_q   <= 4'd0;
            ovf_q    <= 1'b0;
            disp_q   <= {4{8'h00}};
            presc_q  <= 20'd0;
            idx_q    <= 2'd0;
            anodo_q  <= 4'b1110;
            digito_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            iter_q   <= iter_d;
            ovf_q    <= ovf_d;
            disp_q   <= disp_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            anodo_q  <= anodo_d;
            digito_q <= digito_d;
        end
    end

    assign ocupado_out = (state_q != IDLE);
    assign anodo_out   = anodo_q;
    assign digito_out  = digito_q;

endmodule

// File: tb/tb_control_display.sv
// Directed bench for control_display with SCAN_DIV=4: table of loads plus hand sequences for reload-while-busy and mid-conversion reset.
module tb_control_display;

    typedef struct {
        logic [13:0]     val;
        logic [3:0][7:0] dig;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] valor;
    logic        cargar;
    logic        ocupado;
    logic [7:0]  digito;
    logic [3:0]  anodo;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [3:0][7:0] prev;

    always #5 clk = ~clk;

    control_display #(.SCAN_DIV(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .valor_in    (valor),
        .cargar_in   (cargar),
        .ocupado_out (ocupado),
        .digito_out  (digito),
        .anodo_out   (anodo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] exp_an(input int slot, input logic [3:0][7:0] d);
        logic [3:0] a;
        a = ~(4'b0001 << slot);
`ifdef BLANK_LEADING_ZEROS_EN
        if (slot > 0) begin
            logic all_zero;
            all_zero = 1'b1;
            for (int j = slot; j < 4; j++) begin
                if (d[j] != 8'h00) all_zero = 1'b0;
            end
            if (all_zero) a = 4'b1111;
        end
`endif
        return a;
    endfunction

    task automatic check_scan(input string name, input logic [3:0][7:0] d);
        int slot;
        logic [3:0] e;
        slot = (cyc / 4) % 4;
        e = exp_an(slot, d);
        check({name, "_anodo"}, {28'd0, anodo}, {28'd0, e});
        if (e != 4'b1111) begin
            check({name, "_digito"}, {24'd0, digito}, {24'd0, d[slot]});
        end
    endtask

    // Load v, optionally pulse a second load at busy cycle dup_at, then check busy window and 16 scan cycles.
    task automatic load_and_check(input string name, input logic [13:0] v,
                                  input logic [3:0][7:0] d, input int dup_at);
        valor  = v;
        cargar = 1'b1;
        tick();
        cargar = 1'b0;
        for (int k = 0; k < 15; k++) begin
            check({name, "_busy"}, {31'd0, ocupado}, 32'd1);
            check_scan({name, "_hold"}, prev);
            if (k == dup_at) begin
                valor  = 14'd42;
                cargar = 1'b1;
            end
            tick();
            cargar = 1'b0;
        end
        check({name, "_done"}, {31'd0, ocupado}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            check_scan(name, d);
            tick();
        end
        prev = d;
    endtask

    initial begin
        vec_t vecs[8];
        vecs[0] = '{val: 14'd1234,  dig: 32'h01020304};
        vecs[1] = '{val: 14'd9999,  dig: 32'h09090909};
        vecs[2] = '{val: 14'd10000, dig: 32'hFFFFFFFF};
        vecs[3] = '{val: 14'd0,     dig: 32'h00000000};
        vecs[4] = '{val: 14'd50,    dig: 32'h00000500};
        vecs[5] = '{val: 14'd16383, dig: 32'hFFFFFFFF};
        vecs[6] = '{val: 14'd9000,  dig: 32'h09000000};
        vecs[7] = '{val: 14'd1,     dig: 32'h00000001};

        rst    = 1'b1;
        cargar = 1'b0;
        valor  = 14'd0;
        prev   = 32'h00000000;
        repeat (3) tick();
        check("rst_busy",   {31'd0, ocupado}, 32'd0);
        check("rst_anodo",  {28'd0, anodo},   32'hE);
        check("rst_digito", {24'd0, digito},  32'h00);
        rst = 1'b0;
        cyc = 0;
        repeat (5) begin
            check_scan("idle_scan", prev);
            tick();
        end

        for (int i = 0; i < 8; i++) begin
            load_and_check($sformatf("vec%0d", i), vecs[i].val, vecs[i].dig, -1);
        end

        load_and_check("reload_ignored", 14'd567, 32'h00050607, 5);

        valor  = 14'd7;
        cargar = 1'b1;
        tick();
        cargar = 1'b0;
        repeat (8) tick();
        check("abort_busy_pre", {31'd0, ocupado}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy",   {31'd0, ocupado}, 32'd0);
        check("abort_anodo",  {28'd0, anodo},   32'hE);
        check("abort_digito", {24'd0, digito},  32'h00);
        repeat (2) tick();
        rst  = 1'b0;
        cyc  = 0;
        prev = 32'h00000000;
        for (int k = 0; k < 16; k++) begin
            check_scan("abort_scan", prev);
            tick();
        end
        check("abort_idle", {31'd0, ocupado}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
